wb_unit: RTL

Parametrised, registered write-back stage for the core. Accepts one retiring instruction per handshake from the MEM stage and selects the register-file write data: CSR read data, ALU result, or load data. Load data arrives on a separate memory response channel; a small FSM holds the stage until it returns. Load data is byte-aligned, size-selected and sign/zero-extended. Faulting instructions are squashed, and one retire pulse per instruction goes to the commit/difftest logic.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_if.sv | 56 +++++
 rtl/wb_load_ext.sv | 61 ++++++
 rtl/wb_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared definitions for the write-back stage: load size
//                encodings, FSM state type and default datapath widths.
//  Ports       : none (package)
//  Macros      : none
//  Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

   localparam int DEF_XLEN       = 64;
   localparam int DEF_REG_ADDR_W = 5;

   // Load access sizes as carried on in_size
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_if
//  Description : Bundle of the MEM->WB handshake, the load response channel
//                and the register-file / retire outputs of the WB stage.
//  Ports       : master - MEM stage / memory / commit side (drives in_*, mem_*)
//                slave  - write-back stage (drives in_ready, rd_*, retire_*, busy)
//  Macros      : none
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_if
   import wb_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
);
   localparam int OFF_W = $clog2(XLEN/8);

   logic                  in_valid;
   logic                  in_ready;
   logic [XLEN-1:0]       in_alu_result;
   logic [XLEN-1:0]       in_csr_data;
   logic                  in_csr_rena;
   logic                  in_mem_to_reg;
   logic                  in_mem_ext_un;
   logic [1:0]            in_size;
   logic [OFF_W-1:0]      in_addr_off;
   logic [REG_ADDR_W-1:0] in_rd_addr;
   logic                  in_rd_wena;
   logic                  in_exception;
   logic                  mem_rvalid;
   logic [XLEN-1:0]       mem_rdata;
   logic                  mem_rerr;
   logic                  rd_wena;
   logic [REG_ADDR_W-1:0] rd_waddr;
   logic [XLEN-1:0]       rd_wdata;
   logic                  retire_valid;
   logic                  retire_exc;
   logic                  busy;

   modport master (
      output in_valid, in_alu_result, in_csr_data, in_csr_rena, in_mem_to_reg,
             in_mem_ext_un, in_size, in_addr_off, in_rd_addr, in_rd_wena,
             in_exception, mem_rvalid, mem_rdata, mem_rerr,
      input  in_ready, rd_wena, rd_waddr, rd_wdata, retire_valid, retire_exc, busy
   );

   modport slave (
      input  in_valid, in_alu_result, in_csr_data, in_csr_rena, in_mem_to_reg,
             in_mem_ext_un, in_size, in_addr_off, in_rd_addr, in_rd_wena,
             in_exception, mem_rvalid, mem_rdata, mem_rerr,
      output in_ready, rd_wena, rd_waddr, rd_wdata, retire_valid, retire_exc, busy
   );

endinterface
`default_nettype wire

// File: rtl/wb_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : load_ext
//  Description : Combinational load formatter: byte-align, size-select and
//                sign/zero-extend a returned memory word.
//  Ports       : i_rdata  - XLEN-aligned load response word
//                i_off    - byte offset of the access within the word
//                i_size   - access size (SZ_B/SZ_H/SZ_W/SZ_D)
//                i_ext_un - 1: zero-extend, 0: sign-extend
//                o_data   - formatted register write value
//  Macros      : WB_LOAD_ALIGN_EN - when defined, shift the word right by the
//                byte offset; otherwise data is taken as right-justified and
//                i_off is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module load_ext
   import wb_pkg::*;
#(
   parameter int  XLEN  = DEF_XLEN,
   localparam int OFF_W = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0]  i_rdata,
   input  logic [OFF_W-1:0] i_off,
   input  logic [1:0]       i_size,
   input  logic             i_ext_un,
   output logic [XLEN-1:0]  o_data
);

   logic [XLEN-1:0] w_shifted;
   logic [XLEN-1:0] w_mask;
   logic [XLEN-1:0] w_top;
   logic            w_sign;

`ifdef WB_LOAD_ALIGN_EN
   // Logical shift: bytes entering from above the word are zero.
   assign w_shifted = i_rdata >> {i_off, 3'b000};
`else
   logic w_unused_off;
   assign w_unused_off = ^i_off;
   assign w_shifted    = i_rdata;
`endif

   // Keep-mask per size. For XLEN=32 the word mask is already all ones, so a
   // double request degenerates to a word with no extension.
   always_comb begin
      w_mask = '1;
      case (i_size)
         SZ_B:    w_mask = XLEN'(8'hFF);
         SZ_H:    w_mask = XLEN'(16'hFFFF);
         SZ_W:    w_mask = XLEN'(32'hFFFF_FFFF);
         default: w_mask = '1;
      endcase
   end

   // Highest kept bit is the sign bit of the loaded value.
   assign w_top  = w_mask & ~(w_mask >> 1);
   assign w_sign = ~i_ext_un & (|(w_shifted & w_top));
   assign o_data = (w_shifted & w_mask) | ({XLEN{w_sign}} & ~w_mask);

endmodule
`default_nettype wire

// File: rtl/wb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : wb_unit
//  Description : Registered write-back stage. Accepts one retiring
//                instruction per handshake, waits for load data when needed,
//                selects CSR / load / ALU write data, squashes faults and
//                emits one retire pulse per instruction.
//  Ports       : clock - rising-edge clock
//                reset - asynchronous active-high reset
//                bus   - wb_if.slave: MEM handshake, load response channel,
//                        register-file write and retire outputs
//  Macros      : WB_LOAD_ALIGN_EN - enables byte-offset alignment of loads
//  Revision    : 1.0  initial release
// ============================================================================
module wb_unit
   import wb_pkg::*;
#(
   parameter int  XLEN       = DEF_XLEN,
   parameter int  REG_ADDR_W = DEF_REG_ADDR_W,
   localparam int OFF_W      = $clog2(XLEN/8)
) (
   input  logic clock,
   input  logic reset,
   wb_if.slave  bus
);

   wb_state_t             r_state;

   // Decode fields of a load parked while its data is outstanding
   logic                  r_csr_rena;
   logic [XLEN-1:0]       r_csr_data;
   logic                  r_ext_un;
   logic [1:0]            r_size;
   logic [OFF_W-1:0]      r_off;
   logic [REG_ADDR_W-1:0] r_rd_addr;
   logic                  r_rd_wena_req;

   // Output registers
   logic                  r_rd_wena;
   logic [REG_ADDR_W-1:0] r_rd_waddr;
   logic [XLEN-1:0]       r_rd_wdata;
   logic                  r_retire_valid;
   logic                  r_retire_exc;

   logic [XLEN-1:0]       w_load_data;

   load_ext #(.XLEN(XLEN)) u_load_ext (
      .i_rdata  (bus.mem_rdata),
      .i_off    (r_off),
      .i_size   (r_size),
      .i_ext_un (r_ext_un),
      .o_data   (w_load_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_csr_rena     <= 1'b0;
         r_csr_data     <= '0;
         r_ext_un       <= 1'b0;
         r_size         <= SZ_B;
         r_off          <= '0;
         r_rd_addr      <= '0;
         r_rd_wena_req  <= 1'b0;
         r_rd_wena      <= 1'b0;
         r_rd_waddr     <= '0;
         r_rd_wdata     <= '0;
         r_retire_valid <= 1'b0;
         r_retire_exc   <= 1'b0;
      end else begin
         // Outputs are single-cycle pulses; nothing is held across cycles.
         r_rd_wena      <= 1'b0;
         r_rd_waddr     <= '0;
         r_rd_wdata     <= '0;
         r_retire_valid <= 1'b0;
         r_retire_exc   <= 1'b0;

         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (bus.in_mem_to_reg && !bus.in_exception) begin
                     r_csr_rena    <= bus.in_csr_rena;
                     r_csr_data    <= bus.in_csr_data;
                     r_ext_un      <= bus.in_mem_ext_un;
                     r_size        <= bus.in_size;
                     r_off         <= bus.in_addr_off;
                     r_rd_addr     <= bus.in_rd_addr;
                     r_rd_wena_req <= bus.in_rd_wena;
                     r_state       <= WAIT_MEM;
                  end else begin
                     // Non-loads and already-faulted instructions retire now;
                     // a faulted load never waits for memory.
                     r_rd_wena      <= bus.in_rd_wena & ~bus.in_exception &
                                       (bus.in_rd_addr != '0);
                     r_rd_waddr     <= bus.in_rd_addr;
                     r_rd_wdata     <= bus.in_csr_rena ? bus.in_csr_data
                                                       : bus.in_alu_result;
                     r_retire_valid <= 1'b1;
                     r_retire_exc   <= bus.in_exception;
                  end
               end
            end
            WAIT_MEM: begin
               if (bus.mem_rvalid) begin
                  r_rd_wena      <= r_rd_wena_req & ~bus.mem_rerr &
                                    (r_rd_addr != '0);
                  r_rd_waddr     <= r_rd_addr;
                  r_rd_wdata     <= r_csr_rena ? r_csr_data : w_load_data;
                  r_retire_valid <= 1'b1;
                  r_retire_exc   <= bus.mem_rerr;
                  r_state        <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready     = (r_state == IDLE);
   assign bus.busy         = (r_state == WAIT_MEM);
   assign bus.rd_wena      = r_rd_wena;
   assign bus.rd_waddr     = r_rd_waddr;
   assign bus.rd_wdata     = r_rd_wdata;
   assign bus.retire_valid = r_retire_valid;
   assign bus.retire_exc   = r_retire_exc;

endmodule
`default_nettype wire
